// File: rtl/simulate_pkg.sv
// Shared widths, limits and direction type for the LED fade/PWM design.
package simulate_pkg;

    localparam int DUTY_MAX = 1023;
    localparam int PWM_W    = 10;
    localparam int DUTY_W   = 11;
    localparam int SPEED_W  = 11;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

endpackage

// File: rtl/fade_cycle.sv
// Triangle-wave duty generator: a prescaler sets the step rate and the duty
// bounces between 0 and DUTY_MAX, one step per tick.
module fade_cycle
    import simulate_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [SPEED_W-1:0] speed,
    output logic [DUTY_W-1:0]  duty
);

    localparam logic [DUTY_W-1:0] DUTY_TOP = DUTY_W'(DUTY_MAX);

    logic [SPEED_W-1:0] presc_reg;
    logic [SPEED_W-1:0] limit;
    logic               tick;
    dir_t               dir_reg;
    logic [DUTY_W-1:0]  r_count_cur;

    // Speed 0 behaves like 1; >= lets a lowered speed fire at once instead of wrapping.
    always_comb begin
        limit = (speed == '0) ? '0 : speed - SPEED_W'(1);
        tick  = (presc_reg >= limit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_reg   <= '0;
            dir_reg     <= DIR_UP;
            r_count_cur <= '0;
        end else begin
            presc_reg <= tick ? '0 : presc_reg + SPEED_W'(1);
            if (tick) begin
                if (dir_reg == DIR_UP) begin
                    if (r_count_cur == DUTY_TOP) begin
                        dir_reg     <= DIR_DOWN;
                        r_count_cur <= DUTY_TOP - DUTY_W'(1);
                    end else begin
                        r_count_cur <= r_count_cur + DUTY_W'(1);
                    end
                end else begin
                    if (r_count_cur == '0) begin
                        dir_reg     <= DIR_UP;
                        r_count_cur <= DUTY_W'(1);
                    end else begin
                        r_count_cur <= r_count_cur - DUTY_W'(1);
                    end
                end
            end
        end
    end

    assign duty = r_count_cur;

endmodule

// File: rtl/simulate.sv
// LED breathing driver: free-running 10-bit PWM compared against a fading duty.
// Define SIMULATE_REG_OUT_EN to drive o_led from a flop (one extra cycle of latency).
module simulate
    import simulate_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [SPEED_W-1:0] i_speed,
    output logic               o_led
);

    logic [PWM_W-1:0]  pwm_reg;
    logic [DUTY_W-1:0] duty;
    logic              led_next;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pwm_reg <= '0;
        end else begin
            pwm_reg <= pwm_reg + PWM_W'(1);
        end
    end

    fade_cycle simulate_cycle (
        .clk   (i_clk),
        .rst   (i_rst),
        .speed (i_speed),
        .duty  (duty)
    );

    assign led_next = ({1'b0, pwm_reg} < duty);

`ifdef SIMULATE_REG_OUT_EN
    logic led_reg;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            led_reg <= 1'b0;
        end else begin
            led_reg <= led_next;
        end
    end

    assign o_led = led_reg;
`else
    assign o_led = i_rst ? 1'b0 : led_next;
`endif

endmodule

// File: tb/tb_simulate.sv
// Scoreboard bench for simulate: stimulus queues expected values tagged with
// the cycle count since reset release; a negedge monitor pops and compares them.
module tb_simulate;

    localparam int SEL_DUTY  = 0;
    localparam int SEL_DIR   = 1;
    localparam int SEL_LED   = 2;
    localparam int SEL_PRESC = 3;
    localparam int SEL_WSTRT = 4;
    localparam int SEL_WCHK  = 5;
    localparam int SEL_RANGE = 6;

    typedef struct {
        int cyc;
        int sel;
        int val;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] speed = 11'd2;
    logic        led;

    exp_t q[$];
    int   cnt = 0;
    int   checks = 0;
    int   passed = 0;
    int   acc = 0;
    int   max_duty = 0;

    simulate dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_speed (speed),
        .o_led   (led)
    );

    always #5 clk = ~clk;

    // Cycles since reset release: value n after the n-th active edge.
    always @(posedge clk) begin
        if (rst) cnt <= 0;
        else     cnt <= cnt + 1;
    end

    function automatic string sel_name(input int s);
        case (s)
            SEL_DUTY:  return "duty";
            SEL_DIR:   return "dir";
            SEL_LED:   return "led";
            SEL_PRESC: return "presc";
            SEL_WCHK:  return "led_ones";
            SEL_RANGE: return "duty_max";
            default:   return "stale";
        endcase
    endfunction

    // Monitor
    always @(negedge clk) begin
        int act;
        int duty_now;
        duty_now = int'(dut.simulate_cycle.r_count_cur);
        if (duty_now > max_duty) max_duty = duty_now;
        while (q.size() > 0 && q[0].cyc <= cnt) begin
            exp_t e;
            e = q.pop_front();
            if (e.cyc < cnt) begin
                checks++;
                $display("FAIL stale entry sel=%s cyc=%0d seen at cycle %0d", sel_name(e.sel), e.cyc, cnt);
            end else if (e.sel == SEL_WSTRT) begin
                acc = 0;
            end else begin
                case (e.sel)
                    SEL_DUTY:  act = duty_now;
                    SEL_DIR:   act = int'(dut.simulate_cycle.dir_reg);
                    SEL_LED:   act = int'(led);
                    SEL_PRESC: act = int'(dut.simulate_cycle.presc_reg);
                    SEL_WCHK:  act = acc;
                    default:   act = max_duty;
                endcase
                checks++;
                if ((e.sel == SEL_RANGE) ? (act <= e.val) : (act == e.val)) begin
                    passed++;
                    $display("check %s cycle %0d: got %0d expected %0d ok", sel_name(e.sel), cnt, act, e.val);
                end else begin
                    $display("FAIL %s cycle %0d: got %0d expected %0d", sel_name(e.sel), cnt, act, e.val);
                end
            end
        end
        acc += int'(led);
    end

    task automatic push(input int c, input int s, input int v);
        exp_t e;
        e.cyc = c; e.sel = s; e.val = v;
        q.push_back(e);
    endtask

    // Hold reset for n edges, leave it asserted; caller pushes then releases.
    task automatic start(input int n, input logic [10:0] sp);
        rst = 1'b1;
        speed = sp;
        repeat (n) @(posedge clk);
        #1;
        push(0, SEL_DUTY, 0);
        push(0, SEL_DIR, 0);
        push(0, SEL_LED, 0);
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_cnt(input int target);
        int i;
        for (i = 0; i < 20000 && cnt != target; i++) @(negedge clk);
        if (cnt != target) begin
            checks++;
            $display("FAIL wait_cnt: got cycle %0d expected %0d", cnt, target);
        end
    endtask

    task automatic wait_empty();
        int i;
        for (i = 0; i < 20000 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            checks++;
            $display("FAIL wait_empty: got %0d pending expected 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        // Speed 2: full fade cycle and range.
        start(2, 11'd2);
        push(2,    SEL_DUTY, 1);
        push(2046, SEL_DUTY, 1023);
        push(2046, SEL_DIR,  0);
        push(2048, SEL_DUTY, 1022);
        push(2048, SEL_DIR,  1);
        push(4092, SEL_DUTY, 0);
        push(4094, SEL_DUTY, 1);
        push(4094, SEL_DIR,  0);
        push(4200, SEL_RANGE, 1023);
        release_rst();
        wait_empty();

        // Speed 0 steps every cycle.
        start(2, 11'd0);
        push(1,    SEL_DUTY, 1);
        push(1023, SEL_DUTY, 1023);
        push(1024, SEL_DUTY, 1022);
        release_rst();
        wait_empty();

        // Speed 1, then reset at duty 700 while fading down.
        start(2, 11'd1);
        push(1,    SEL_DUTY, 1);
        push(1023, SEL_DUTY, 1023);
        push(1346, SEL_DUTY, 700);
        push(1346, SEL_DIR,  1);
        release_rst();
        wait_cnt(1346);
        start(1, 11'd1);
        release_rst();
        wait_empty();

        // Duty held at 0: LED dark for a full PWM period.
        start(2, 11'd2047);
        push(5,    SEL_WSTRT, 0);
        push(1029, SEL_WCHK,  0);
        push(1029, SEL_DUTY,  0);
        release_rst();
        wait_empty();

        // Duty held at 512: LED lit for exactly half the period.
        start(2, 11'd1);
        push(512,  SEL_DUTY,  512);
        push(520,  SEL_WSTRT, 0);
        push(1544, SEL_WCHK,  512);
        push(1544, SEL_DUTY,  512);
        release_rst();
        wait_cnt(512);
        speed = 11'd2047;
        wait_empty();

        // Speed lowered 100 -> 3 with the prescaler already at 50.
        start(2, 11'd100);
        push(50, SEL_PRESC, 50);
        push(50, SEL_DUTY,  0);
        push(51, SEL_PRESC, 0);
        push(51, SEL_DUTY,  1);
        push(52, SEL_PRESC, 1);
        push(53, SEL_PRESC, 2);
        push(54, SEL_PRESC, 0);
        push(54, SEL_DUTY,  2);
        release_rst();
        wait_cnt(50);
        speed = 11'd3;
        wait_empty();

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
